ysyx_22041207_pipe_stage: RTL and testbench

YSYX_22041207_PIPE_STAGE -- requirements
Module: ysyx_22041207_pipe_stage

---
 rtl/ysyx_22041207_pipe_stage.sv | 108 ++++++++++
 tb/tb_ysyx_22041207_pipe_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_pipe_stage.sv
// Valid/ready pipeline stage: one main entry plus an optional skid entry.
// SKID=1 registers in_ready so there is no out_ready -> in_ready path;
// SKID=0 collapses to a single-entry stage with combinational in_ready.
module ysyx_22041207_pipe_stage #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned SKID           = 1,
  parameter int unsigned CLEAR_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              ready_q;
  logic              in_fire, out_fire;

  // Handshake decode and output view of the held entries
  always_comb begin
    out_valid = (state != EMPTY);
    out_data  = main_q;
    // ready_q is 0 in reset and equals (state != TWO) afterwards; with SKID=0
    // TWO is unreachable, so it acts purely as the out-of-reset qualifier.
    if (SKID != 0) in_ready = ready_q;
    else           in_ready = ready_q & (~out_valid | out_ready);
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and payload update; flush overrides every other event
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = ONE;
          main_nxt  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_nxt = in_data;
        end else if (in_fire && (SKID != 0)) begin
          state_nxt = TWO;
          skid_nxt  = in_data;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_nxt = ONE;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_nxt = '0;
        skid_nxt = '0;
      end else begin
        main_nxt = main_q;
        skid_nxt = skid_q;
      end
    end
  end

  // State, payload and registered ready flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      main_q  <= main_nxt;
      skid_q  <= skid_nxt;
      ready_q <= (state_nxt != TWO);
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_pipe_stage.sv
// Directed bench: instance a = SKID=1/CLEAR=1, instance b = SKID=0/CLEAR=0.
module tb_ysyx_22041207_pipe_stage;

  logic        clk;
  logic        rst_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ysyx_22041207_pipe_stage #(.DATA_W(64), .SKID(1), .CLEAR_ON_FLUSH(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  ysyx_22041207_pipe_stage #(.DATA_W(64), .SKID(0), .CLEAR_ON_FLUSH(0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] q[$];
    logic        f, iv, orr, exp_rdy, inf, outf;
    logic [63:0] d;

    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;

    // Reset state
    #2;
    chk("rst_a_ready", a_in_ready, 0);
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_b_ready", b_in_ready, 0);
    #10 rst_n = 1'b1;  // t=12, between edges
    #1;
    chk("rel_a_ready_pre_edge", a_in_ready, 0);
    tick();
    chk("rel_a_ready", a_in_ready, 1);
    chk("rel_b_ready", b_in_ready, 1);

    // Single pass 0xA5
    a_in_valid = 1; a_in_data = 64'hA5; a_out_ready = 1;
    #1 chk("single_pre_valid", a_out_valid, 0);
    tick();
    a_in_valid = 0;
    chk("single_valid", a_out_valid, 1);
    chk("single_data", a_out_data, 64'hA5);
    chk("single_occ1", a_occ, 1);
    tick();
    chk("single_occ0", a_occ, 0);
    chk("single_drain", a_out_valid, 0);

    // Backpressure 0x11/0x22/0x33
    a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h11;
    tick();
    chk("bp_occ1", a_occ, 1);
    chk("bp_ready1", a_in_ready, 1);
    a_in_data = 64'h22;
    tick();
    chk("bp_occ2", a_occ, 2);
    chk("bp_ready0", a_in_ready, 0);
    a_in_data = 64'h33;
    tick();
    chk("bp_hold_occ", a_occ, 2);
    chk("bp_hold_data", a_out_data, 64'h11);
    a_out_ready = 1;
    tick();
    chk("bp_out22", a_out_data, 64'h22);
    chk("bp_occ_after", a_occ, 1);
    chk("bp_reready", a_in_ready, 1);
    tick();
    a_in_valid = 0;
    chk("bp_out33", a_out_data, 64'h33);
    chk("bp_occ33", a_occ, 1);
    tick();
    chk("bp_empty", a_occ, 0);

    // Flush in TWO with a concurrent offer
    a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h44;
    tick();
    a_in_data = 64'h55;
    tick();
    chk("fl_occ2", a_occ, 2);
    a_in_data = 64'h66; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    chk("fl_occ", a_occ, 0);
    chk("fl_valid", a_out_valid, 0);
    chk("fl_data", a_out_data, 0);
    chk("fl_ready", a_in_ready, 1);
    tick();
    chk("fl_no66", a_out_valid, 0);

    // Asynchronous reset with two held entries
    a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h77;
    tick();
    a_in_data = 64'h88;
    tick();
    a_in_valid = 0;
    chk("ar_occ2", a_occ, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_occ", a_occ, 0);
    chk("ar_valid", a_out_valid, 0);
    chk("ar_data", a_out_data, 0);
    chk("ar_ready", a_in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_ready_back", a_in_ready, 1);

    // Streaming 100 beats on both instances
    a_out_ready = 1; b_out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      a_in_valid = 1; b_in_valid = 1;
      a_in_data = 64'(i + 1); b_in_data = 64'(i + 1000);
      #1;
      chk("st_a_ready", a_in_ready, 1);
      chk("st_b_ready", b_in_ready, 1);
      tick();
      chk("st_a_valid", a_out_valid, 1);
      chk("st_a_data", a_out_data, 64'(i + 1));
      chk("st_b_valid", b_out_valid, 1);
      chk("st_b_data", b_out_data, 64'(i + 1000));
    end
    a_in_valid = 0; b_in_valid = 0;
    tick();
    chk("st_a_drain", a_occ, 0);
    chk("st_b_drain", b_occ, 0);

    // SKID=0: combinational ready, flush keeps payload
    b_out_ready = 0; b_in_valid = 1; b_in_data = 64'h5A;
    tick();
    b_in_valid = 0;
    chk("b_full_valid", b_out_valid, 1);
    chk("b_full_ready", b_in_ready, 0);
    b_out_ready = 1;
    #1 chk("b_comb_ready", b_in_ready, 1);
    b_out_ready = 0; b_flush = 1;
    tick();
    b_flush = 0;
    chk("b_fl_valid", b_out_valid, 0);
    chk("b_fl_data_held", b_out_data, 64'h5A);
    chk("b_fl_occ", b_occ, 0);
    chk("b_fl_ready", b_in_ready, 1);

    // Random traffic on instance a against a queue model
    for (int c = 0; c < 3000; c++) begin
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      f   = ($urandom_range(0, 40) == 0);
      d   = {$urandom(), $urandom()};
      a_in_valid = iv; a_out_ready = orr; a_flush = f; a_in_data = d;
      #1;
      exp_rdy = (q.size() < 2);
      chk("rnd_ready", a_in_ready, exp_rdy);
      chk("rnd_occ", a_occ, 64'(q.size()));
      chk("rnd_valid", a_out_valid, (q.size() > 0));
      if (q.size() > 0) chk("rnd_data", a_out_data, q[0]);
      inf  = iv & exp_rdy;
      outf = orr & (q.size() > 0);
      tick();
      if (f) q.delete();
      else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(d);
      end
    end
    a_in_valid = 0; a_flush = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
